// File: rtl/playback_stream_arbiter.sv
// Round-robin burst arbiter sharing one playback FIFO between AXI4-Stream producers.
// A burst starts only when the FIFO has room for a full BURST_LEN beats.
module playback_stream_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 512,
    parameter int GAP_CYCLES = 3,
    localparam int GW = $clog2(NUM_REQ)
) (
    input  logic                   axis_aclk,
    input  logic                   axis_aresetn,
    input  logic                   enable,
    input  logic [NUM_REQ-1:0]     s_axis_tvalid,
    output logic [NUM_REQ-1:0]     s_axis_tready,
    input  logic [64*NUM_REQ-1:0]  s_axis_tdata,
    input  logic [NUM_REQ-1:0]     s_axis_tlast,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [63:0]            m_axis_tdata,
    input  logic [31:0]            fifo_wr_data_count,
    output logic [GW-1:0]          grant_id,
    output logic                   busy,
    output logic [31:0]            burst_count
);

    localparam int BW = $clog2(BURST_LEN);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_XFER = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [31:0] DEPTH32   = 32'(FIFO_DEPTH);
    localparam logic [31:0] BURST32   = 32'(BURST_LEN);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
    localparam logic [3:0] GAP_LOAD  = 4'(GAP_CYCLES);

    logic [1:0]    state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] last_q, last_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [3:0]    gap_q, gap_d;
    logic [31:0]   bursts_q, bursts_d;

    logic [31:0]   free;
    logic [GW-1:0] winner;
    logic          found;
    logic          xfer;
    logic          sel_valid;
    logic          sel_last;
    logic          hs;

    assign free = (fifo_wr_data_count < DEPTH32) ? (DEPTH32 - fifo_wr_data_count) : 32'd0;

    // Search starts just past the last grant so every requester gets a turn.
    always_comb begin
        winner = last_q;
        found  = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && s_axis_tvalid[(int'(last_q) + k) % NUM_REQ]) begin
                found  = 1'b1;
                winner = GW'((int'(last_q) + k) % NUM_REQ);
            end
        end
    end

    assign xfer      = (state_q == S_XFER);
    assign sel_valid = s_axis_tvalid[grant_q];
    assign sel_last  = s_axis_tlast[grant_q];
    assign hs        = xfer && sel_valid && m_axis_tready;

    assign m_axis_tvalid = xfer && sel_valid;
    assign m_axis_tdata  = xfer ? s_axis_tdata[int'(grant_q)*64 +: 64] : 64'd0;
    assign s_axis_tready = xfer ? (NUM_REQ'(m_axis_tready) << grant_q) : '0;
    assign busy          = xfer;
    assign grant_id      = grant_q;
    assign burst_count   = bursts_q;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        beat_d   = beat_q;
        gap_d    = gap_q;
        bursts_d = bursts_q;
        case (state_q)
            S_IDLE: begin
                if (enable && found && (free >= BURST32)) begin
                    grant_d = winner;
                    last_d  = winner;
                    beat_d  = '0;
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                if (hs) begin
                    beat_d = beat_q + 1'b1;
                    if ((beat_q == LAST_BEAT) || sel_last) begin
                        bursts_d = bursts_q + 32'd1;
                        gap_d    = GAP_LOAD;
                        state_d  = S_GAP;
                    end
                end
            end
            S_GAP: begin
                gap_d = gap_q - 4'd1;
                if (gap_q == 4'd1) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            last_q   <= GW'(NUM_REQ - 1);
            beat_q   <= '0;
            gap_q    <= '0;
            bursts_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            beat_q   <= beat_d;
            gap_q    <= gap_d;
            bursts_q <= bursts_d;
        end
    end

endmodule

// File: tb/tb_playback_stream_arbiter.sv
// Scoreboard bench for playback_stream_arbiter: expected beats are queued
// as stimulus is set up and popped as the FIFO side accepts data.
module tb_playback_stream_arbiter;

    logic         clk;
    logic         rst_n;
    logic         enable;
    logic [3:0]   s_tvalid;
    logic [3:0]   s_tready;
    logic [255:0] s_tdata;
    logic [3:0]   s_tlast;
    logic         m_tvalid;
    logic         m_tready;
    logic [63:0]  m_tdata;
    logic [31:0]  count;
    logic [1:0]   grant_id;
    logic         busy;
    logic [31:0]  burst_count;

    int compared = 0;
    int failed = 0;
    int cyc;
    int cnt[4];
    int tlast_at[4];
    logic [63:0] q[$];
    int beat_cycles[$];

    playback_stream_arbiter dut (
        .axis_aclk(clk),
        .axis_aresetn(rst_n),
        .enable(enable),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .s_axis_tdata(s_tdata),
        .s_axis_tlast(s_tlast),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .m_axis_tdata(m_tdata),
        .fifo_wr_data_count(count),
        .grant_id(grant_id),
        .busy(busy),
        .burst_count(burst_count)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    always_comb begin
        s_tdata = '0;
        s_tlast = '0;
        for (int i = 0; i < 4; i++) begin
            s_tdata[64*i +: 64] = (64'(i) << 16) + 64'(cnt[i]);
            s_tlast[i] = (tlast_at[i] == cnt[i]);
        end
    end

    function automatic logic [63:0] beat(input int r, input int n);
        return (64'(r) << 16) + 64'(n);
    endfunction

    task automatic cycle();
        logic hs;
        logic [63:0] d;
        logic [63:0] e;
        logic [1:0] g;
        logic [3:0] h;
        #1;
        hs = m_tvalid && m_tready;
        d = m_tdata;
        g = grant_id;
        h = s_tvalid & s_tready;
        compared++;
        if (!$onehot0(s_tready)) begin
            failed++;
            $display("FAIL ready_onehot: got %b, need at most one bit", s_tready);
        end
        compared++;
        if (m_tvalid && !busy) begin
            failed++;
            $display("FAIL valid_outside_xfer: m_tvalid=1 busy=%b, need busy=1", busy);
        end
        if (hs) begin
            if (q.size() == 0) begin
                compared++;
                failed++;
                $display("FAIL unexpected_beat: got %h, expected no beat", d);
            end else begin
                e = q.pop_front();
                compared++;
                if (d !== e) begin
                    failed++;
                    $display("FAIL beat_data: got %h, expected %h", d, e);
                end
                compared++;
                if (g !== e[17:16]) begin
                    failed++;
                    $display("FAIL beat_grant: got %0d, expected %0d", g, e[17:16]);
                end
                beat_cycles.push_back(cyc);
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            if (h[i]) cnt[i]++;
        cyc++;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (q.size() > 0 && n < budget) begin
            cycle();
            n++;
        end
        if (q.size() > 0) begin
            compared++;
            failed++;
            $display("FAIL %s_timeout: %0d beats left, expected 0", name, q.size());
            q.delete();
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 0;
        enable = 1;
        s_tvalid = '0;
        m_tready = 1;
        count = 0;
        for (int i = 0; i < 4; i++) begin
            cnt[i] = 0;
            tlast_at[i] = -1;
        end
        q.delete();
        beat_cycles.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        @(posedge clk);
        #1;
        cyc = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        #3;
        check32("rst_tready", 32'(s_tready), 0);
        check32("rst_mvalid", 32'(m_tvalid), 0);
        check32("rst_busy", 32'(busy), 0);
        check32("rst_grant", 32'(grant_id), 0);
        check32("rst_bursts", burst_count, 0);
        do_reset();
        check32("post_rst_busy", 32'(busy), 0);
    endtask

    task automatic test_single_req();
        do_reset();
        s_tvalid = 4'b0100;
        for (int k = 0; k < 32; k++) q.push_back(beat(2, k));
        drain("single", 200);
        s_tvalid = '0;
        check32("single_bursts", burst_count, 2);
        if (beat_cycles.size() == 32) begin
            check32("single_latency", 32'(beat_cycles[0]), 1);
            check32("single_gap", 32'(beat_cycles[16] - beat_cycles[15]), 5);
        end else begin
            compared++;
            failed++;
            $display("FAIL single_count: got %0d beats, expected 32", beat_cycles.size());
        end
        idle(8);
        check32("single_idle_busy", 32'(busy), 0);
    endtask

    task automatic test_round_robin();
        do_reset();
        s_tvalid = 4'b1111;
        for (int b = 0; b < 5; b++)
            for (int k = 0; k < 16; k++) q.push_back(beat(b % 4, (b / 4) * 16 + k));
        drain("rr", 400);
        s_tvalid = '0;
        check32("rr_bursts", burst_count, 5);
        idle(6);
    endtask

    task automatic test_free_space();
        do_reset();
        count = 497;
        s_tvalid = 4'b0001;
        idle(10);
        check32("full_busy", 32'(busy), 0);
        check32("full_bursts", burst_count, 0);
        count = 496;
        cycle();
        check32("room_busy", 32'(busy), 1);
        check32("room_grant", 32'(grant_id), 0);
        for (int k = 0; k < 16; k++) q.push_back(beat(0, k));
        drain("room", 100);
        s_tvalid = '0;
        count = 0;
        idle(6);
    endtask

    task automatic test_tlast();
        int n = 0;
        do_reset();
        s_tvalid = 4'b0110;
        tlast_at[1] = 4;
        for (int k = 0; k < 5; k++) q.push_back(beat(1, k));
        for (int k = 0; k < 16; k++) q.push_back(beat(2, k));
        while (q.size() > 16 && n < 50) begin
            cycle();
            n++;
        end
        check32("tlast_bursts1", burst_count, 1);
        drain("tlast", 100);
        s_tvalid = '0;
        check32("tlast_bursts2", burst_count, 2);
        idle(6);
    endtask

    task automatic test_backpressure();
        int n = 0;
        do_reset();
        s_tvalid = 4'b0001;
        m_tready = 0;
        for (int k = 0; k < 16; k++) q.push_back(beat(0, k));
        while (q.size() > 0 && n < 200) begin
            m_tready = ~m_tready;
            if (beat_cycles.size() >= 8) enable = 0;
            cycle();
            n++;
        end
        if (q.size() > 0) begin
            compared++;
            failed++;
            $display("FAIL bp_timeout: %0d beats left, expected 0", q.size());
            q.delete();
        end
        m_tready = 1;
        check32("bp_enable_low", 32'(enable), 0);
        check32("bp_bursts", burst_count, 1);
        idle(12);
        check32("bp_no_grant", 32'(busy), 0);
        check32("bp_bursts_hold", burst_count, 1);
        s_tvalid = '0;
        enable = 1;
    endtask

    task automatic test_reset_midburst();
        int n = 0;
        do_reset();
        s_tvalid = 4'b1000;
        for (int k = 0; k < 16; k++) q.push_back(beat(3, k));
        while (beat_cycles.size() < 7 && n < 50) begin
            cycle();
            n++;
        end
        rst_n = 0;
        #1;
        check32("mid_rst_tready", 32'(s_tready), 0);
        check32("mid_rst_mvalid", 32'(m_tvalid), 0);
        check32("mid_rst_tdata", m_tdata[31:0], 0);
        check32("mid_rst_busy", 32'(busy), 0);
        check32("mid_rst_grant", 32'(grant_id), 0);
        check32("mid_rst_bursts", burst_count, 0);
        q.delete();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        beat_cycles.delete();
        rst_n = 1;
        s_tvalid = 4'b1111;
        for (int k = 0; k < 16; k++) q.push_back(beat(0, k));
        drain("after_rst", 100);
        s_tvalid = '0;
        check32("after_rst_bursts", burst_count, 1);
        idle(6);
    endtask

    initial begin
        rst_n = 1;
        enable = 1;
        s_tvalid = '0;
        m_tready = 1;
        count = 0;
        cyc = 0;
        for (int i = 0; i < 4; i++) begin
            cnt[i] = 0;
            tlast_at[i] = -1;
        end
        test_reset();
        test_single_req();
        test_round_robin();
        test_free_space();
        test_tlast();
        test_backpressure();
        test_reset_midburst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
